// File: rtl/instr_fetch_ram_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and PC constants.
package instr_fetch_ram_pkg;

    typedef enum logic [2:0] {
        ST_GAP   = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] INSTR_STEP       = 32'(INSTR_BYTES);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_ram_pc_npc.sv
// SPARC PC/nPC pair; a load (redirect) overrides a sequential advance.
module pc_npc_reg
    import instr_fetch_ram_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_advance,
    input  logic        i_load,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] r_npc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + INSTR_STEP;
        end else if (i_load) begin
            r_pc  <= i_target;
            r_npc <= i_target + INSTR_STEP;
        end else if (i_advance) begin
            r_pc  <= r_npc;
            r_npc <= r_npc + INSTR_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_ram.sv
// Fetch stage in front of ram128x32: one enable pulse per word read, result
// held on a valid/ready port to decode; redirects restart or park the fetcher.
module instr_fetch_ram
    import instr_fetch_ram_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          RAM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [31:0]       if_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              misalign_err
);

    localparam logic [2:0] LAT_INIT = 3'(RAM_LAT - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [2:0]        r_lat_cnt;
    logic              r_ram_enable;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_instr;
    logic [31:0]       r_if_pc;
    logic              r_misalign_err;
    logic [31:0]       w_pc;
    logic              w_issue;
    logic              w_capture;
    logic              w_xfer;
    logic              w_load;
    logic              w_misalign;

    pc_npc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_npc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_capture),
        .i_load    (w_load),
        .i_target  (redirect_target),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_GAP;
        else        r_state <= w_state_nxt;
    end

    // Redirect pre-empts every state, so a capture in the same cycle is lost.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        w_load      = 1'b0;
        w_misalign  = 1'b0;
        if (redirect_valid) begin
            if (is_word_aligned(redirect_target)) begin
                w_load      = 1'b1;
                w_state_nxt = ST_GAP;
            end else begin
                w_misalign  = 1'b1;
                w_state_nxt = ST_ERR;
            end
        end else begin
            case (r_state)
                ST_GAP:   w_state_nxt = ST_ISSUE;
                ST_ISSUE: begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_if_valid && if_ready) begin
                        w_xfer      = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_ERR:   w_state_nxt = ST_ERR;
                default:  w_state_nxt = ST_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt      <= 3'd0;
            r_ram_enable   <= 1'b0;
            r_ram_address  <= '0;
            r_if_valid     <= 1'b0;
            r_if_instr     <= '0;
            r_if_pc        <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= w_misalign;
            if (redirect_valid) begin
                r_if_valid   <= 1'b0;
                r_ram_enable <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_ram_enable  <= 1'b1;
                    r_ram_address <= w_pc[ADDR_W+1:2];
                    r_lat_cnt     <= LAT_INIT;
                end
                if (r_state == ST_WAIT && !w_capture) begin
                    r_lat_cnt <= r_lat_cnt - 3'd1;
                end
                if (w_capture) begin
                    r_if_instr   <= ram_data_out;
                    r_if_pc      <= w_pc;
                    r_if_valid   <= 1'b1;
                    r_ram_enable <= 1'b0;
                end
                if (w_xfer) begin
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    assign ram_enable     = r_ram_enable;
    assign ram_read_write = 1'b1;
    assign ram_address    = r_ram_address;
    assign ram_data_in    = '0;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign misalign_err   = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_ram.sv
// Bench for instr_fetch_ram: RAM model, expected-fetch queue, redirect vector table.
module tb_instr_fetch_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        ram_enable, ram_read_write, if_valid, if_ready, redirect_valid, misalign_err;
    logic [6:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out, if_instr, if_pc, redirect_target;

    logic        ram_enable3, ram_read_write3, if_valid3, if_ready3, redirect_valid3, misalign_err3;
    logic [6:0]  ram_address3;
    logic [31:0] ram_data_in3, ram_data_out3, if_instr3, if_pc3, redirect_target3;

    logic [31:0] mem [128];
    int unsigned en3_cnt = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) en3_cnt <= ram_enable3 ? en3_cnt + 1 : 0;

    // Data is only meaningful once enable has been high for the configured latency.
    assign ram_data_out  = ram_enable ? mem[ram_address] : 32'hDEAD_BEEF;
    assign ram_data_out3 = (ram_enable3 && en3_cnt == 2) ? mem[ram_address3] : 32'hDEAD_BEEF;

    instr_fetch_ram #(.ADDR_W(7), .DATA_W(32), .RESET_PC(32'h0), .RAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ram_enable(ram_enable), .ram_read_write(ram_read_write),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .misalign_err(misalign_err));

    instr_fetch_ram #(.ADDR_W(7), .DATA_W(32), .RESET_PC(32'h0), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ram_enable(ram_enable3), .ram_read_write(ram_read_write3),
        .ram_address(ram_address3), .ram_data_in(ram_data_in3), .ram_data_out(ram_data_out3),
        .if_valid(if_valid3), .if_ready(if_ready3), .if_instr(if_instr3), .if_pc(if_pc3),
        .redirect_valid(redirect_valid3), .redirect_target(redirect_target3), .misalign_err(misalign_err3));

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] target; logic mis; int nfetch; } redir_vec_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem[e.pc[8:2]];
            q.push_back(e);
        end
    endtask

    // Pops one expectation per handshake; parks decode (if_ready=0) once empty.
    task automatic drain(input int period, input int budget);
        exp_t e;
        int   last;
        int   spent;
        last  = -1;
        spent = 0;
        while (q.size() > 0 && spent < budget) begin
            @(negedge clk);
            spent++;
            if (if_valid && if_ready && !redirect_valid) begin
                e = q.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
                if (last >= 0) check("fetch_period", 32'(cyc - last), 32'(period));
                last = cyc;
            end
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d fetches missing, expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1 if_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = target;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic wait_enable(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ram_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ram_enable) begin
            checks++;
            errors++;
            $display("FAIL %s: ram_enable never rose, got 0 expected 1", name);
        end
    endtask

    redir_vec_t vecs[6];
    int         bad;
    int         pops3, run3, last3;
    exp_t       e3;

    initial begin
        vecs[0] = '{target: 32'h0000_0100, mis: 1'b0, nfetch: 3};
        vecs[1] = '{target: 32'h0000_0006, mis: 1'b1, nfetch: 0};
        vecs[2] = '{target: 32'h0000_0008, mis: 1'b0, nfetch: 2};
        vecs[3] = '{target: 32'hFFFF_FFFC, mis: 1'b0, nfetch: 2};
        vecs[4] = '{target: 32'h0000_0001, mis: 1'b1, nfetch: 0};
        vecs[5] = '{target: 32'h0000_0040, mis: 1'b0, nfetch: 2};

        for (int i = 0; i < 128; i++) mem[i] = (i < 10) ? 32'(i * 3) : (32'hA500_0000 | 32'(i));

        rst_n = 1'b0;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        if_ready3 = 1'b1; redirect_valid3 = 1'b0; redirect_target3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_enable", {31'b0, ram_enable}, 32'd0);
        check("rst_ram_rw", {31'b0, ram_read_write}, 32'd1);
        check("rst_ram_addr", {25'b0, ram_address}, 32'd0);
        check("rst_ram_din", ram_data_in, 32'd0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst3_rw_din", {ram_read_write3, ram_data_in3[30:0]}, 32'h8000_0000);
        rst_n = 1'b1;

        // First capture with decode stalled: output must hold and no new fetch may start.
        bad = 0;
        while (!if_valid && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        check("first_capture_valid", {31'b0, if_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_enable", {31'b0, ram_enable}, 32'd0);
        end
        check("stall_instr", if_instr, 32'd0);
        check("stall_pc", if_pc, 32'd0);
        push_run(32'h0, 10);
        @(posedge clk);
        #1 if_ready = 1'b1;
        drain(3, 60);

        // Redirect vector table.
        for (int v = 0; v < 6; v++) begin
            pulse_redirect(vecs[v].target);
            @(negedge clk);
            check("redir_misalign", {31'b0, misalign_err}, {31'b0, vecs[v].mis});
            check("redir_valid_clr", {31'b0, if_valid}, 32'd0);
            if (vecs[v].mis) begin
                bad = 0;
                @(negedge clk);
                check("misalign_pulse_end", {31'b0, misalign_err}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    if (ram_enable || if_valid) bad++;
                    @(negedge clk);
                end
                check("err_no_fetch_cycles", 32'(bad), 32'd0);
            end else begin
                push_run(vecs[v].target, vecs[v].nfetch);
                if_ready = 1'b1;
                drain(3, vecs[v].nfetch * 3 + 20);
            end
        end

        // Redirect while the RAM read is in flight: that word must never appear.
        pulse_redirect(32'h0000_0020);
        wait_enable("wait_redirect");
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_01F0;
        if_ready        = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wait_redir_drop", {31'b0, if_valid}, 32'd0);
        check("wait_redir_enable", {31'b0, ram_enable}, 32'd0);
        push_run(32'h0000_01F0, 5);
        drain(3, 40);

        // Reset in the middle of a read.
        pulse_redirect(32'h0000_0040);
        wait_enable("wait_reset");
        rst_n = 1'b0;
        #1;
        check("midrst_enable", {31'b0, ram_enable}, 32'd0);
        check("midrst_addr", {25'b0, ram_address}, 32'd0);
        check("midrst_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_pc_instr", if_pc | if_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_run(32'h0, 2);
        if_ready = 1'b1;
        drain(3, 30);

        // Latency-3 instance from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        push_run(32'h0, 4);
        pops3 = 0; run3 = 0; last3 = -1;
        for (int i = 0; i < 80 && pops3 < 4; i++) begin
            @(negedge clk);
            if (ram_enable3) run3++;
            else if (run3 > 0) begin
                check("lat3_enable_run", 32'(run3), 32'd3);
                run3 = 0;
            end
            if (if_valid3 && q.size() > 0) begin
                e3 = q.pop_front();
                check("lat3_pc", if_pc3, e3.pc);
                check("lat3_instr", if_instr3, e3.instr);
                if (last3 >= 0) check("lat3_period", 32'(cyc - last3), 32'd5);
                last3 = cyc;
                pops3++;
            end
        end
        check("lat3_fetch_count", 32'(pops3), 32'd4);
        check("lat3_misalign", {31'b0, misalign_err3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
